// File: rtl/pc_sequencer.sv
// pc_sequencer: sequencing controller for the Y86-64 fetch stage.
//   Owns the architectural PC, fetches one instruction, issues it to the back-end,
//   waits for wb_done, then selects the next PC (valP / valC / valM) and tracks stat.
// Ports: clk/rst (sync, active-high); start; pc/fetch_en to fetch; icode/ifun/valC/valP/
//   halt/instr_valid/imem_error from fetch; issue/icode_q/ifun_q to back-end;
//   wb_done/cnd/valM/dmem_error from back-end; stat/busy status.
// Optional: PC_SEQ_PERF_EN adds a saturating 32-bit instr_retired counter output.
module pc_sequencer #(
  parameter int unsigned   PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  input  logic [3:0]      icode,
  input  logic [3:0]      ifun,
  input  logic [63:0]     valC,
  input  logic [63:0]     valP,
  input  logic            halt,
  input  logic            instr_valid,
  input  logic            imem_error,
  output logic            issue,
  output logic [3:0]      icode_q,
  output logic [3:0]      ifun_q,
  input  logic            wb_done,
  input  logic            cnd,
  input  logic [63:0]     valM,
  input  logic            dmem_error,
  output logic [2:0]      stat,
  output logic            busy
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]     instr_retired
`endif
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] valc_q, valc_nx;
  logic [PC_W-1:0] valp_q, valp_nx;
  logic [PC_W-1:0] next_pc;
  logic [3:0]      icode_nx, ifun_nx;
  logic [2:0]      stat_nx;
  logic            issue_nx;
  logic            retire;

  // Fetch values are truncated / zero-extended to PC_W; addresses wrap mod 2^PC_W.
  logic [PC_W-1:0] valc_in, valp_in, valm_in;
  assign valc_in = PC_W'(valC);
  assign valp_in = PC_W'(valP);
  assign valm_in = PC_W'(valM);

  assign fetch_en = (state == S_FETCH);
  assign busy     = (state == S_FETCH) || (state == S_EXEC);

  // Target selection uses the latched fetch values so fetch may move on freely.
  always_comb begin
    next_pc = valp_q;
    case (icode_q)
      IC_JXX:  next_pc = cnd ? valc_q : valp_q;
      IC_CALL: next_pc = valc_q;
      IC_RET:  next_pc = valm_in;
      default: next_pc = valp_q;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    valc_nx  = valc_q;
    valp_nx  = valp_q;
    icode_nx = icode_q;
    ifun_nx  = ifun_q;
    stat_nx  = stat;
    issue_nx = 1'b0;
    retire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          state_nx = S_FAULT;
          stat_nx  = STAT_ADR;
        end else if (!instr_valid) begin
          state_nx = S_FAULT;
          stat_nx  = STAT_INS;
        end else if (halt) begin
          state_nx = S_HALTED;
          stat_nx  = STAT_HLT;
        end else begin
          state_nx = S_EXEC;
          icode_nx = icode;
          ifun_nx  = ifun;
          valc_nx  = valc_in;
          valp_nx  = valp_in;
          issue_nx = 1'b1;
        end
      end
      S_EXEC: begin
        if (wb_done) begin
          if (dmem_error) begin
            state_nx = S_FAULT;
            stat_nx  = STAT_ADR;
          end else begin
            state_nx = S_FETCH;
            pc_nx    = next_pc;
            retire   = 1'b1;
          end
        end
      end
      S_HALTED, S_FAULT: begin
        state_nx = state;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      valc_q  <= '0;
      valp_q  <= '0;
      icode_q <= '0;
      ifun_q  <= '0;
      stat    <= STAT_AOK;
      issue   <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      valc_q  <= valc_nx;
      valp_q  <= valp_nx;
      icode_q <= icode_nx;
      ifun_q  <= ifun_nx;
      stat    <= stat_nx;
      issue   <= issue_nx;
    end
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_retired <= '0;
    end else if (retire && (instr_retired != 32'hFFFF_FFFF)) begin
      instr_retired <= instr_retired + 32'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] pc;
  logic        fetch_en;
  logic [3:0]  icode, ifun;
  logic [63:0] valC, valP, valM;
  logic        halt, instr_valid, imem_error;
  logic        issue;
  logic [3:0]  icode_q, ifun_q;
  logic        wb_done, cnd, dmem_error;
  logic [2:0]  stat;
  logic        busy;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] instr_retired;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .fetch_en(fetch_en),
    .icode(icode), .ifun(ifun), .valC(valC), .valP(valP), .halt(halt),
    .instr_valid(instr_valid), .imem_error(imem_error), .issue(issue),
    .icode_q(icode_q), .ifun_q(ifun_q), .wb_done(wb_done), .cnd(cnd),
    .valM(valM), .dmem_error(dmem_error), .stat(stat), .busy(busy)
`ifdef PC_SEQ_PERF_EN
    , .instr_retired(instr_retired)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] c, input logic [63:0] p);
    icode = ic; ifun = fn; valC = c; valP = p;
    halt = 1'b0; instr_valid = 1'b1; imem_error = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; wb_done = 1'b0; dmem_error = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // From IDLE: pulse start so the sequencer enters FETCH.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cnd = 1'b0; valM = '0; wb_done = 1'b0; dmem_error = 1'b0;
    set_fetch(4'h1, 4'h0, 64'h0, 64'h1);

    // 1: reset state, then nop at 0 with wb_done in the issue cycle
    do_reset();
    check("rst_pc", pc, 64'h0);
    check("rst_stat", {61'b0, stat}, 64'd1);
    check("rst_issue", {63'b0, issue}, 64'd0);
    check("rst_icode_q", {60'b0, icode_q}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_fetch_en", {63'b0, fetch_en}, 64'd0);
`ifdef PC_SEQ_PERF_EN
    check("rst_retired", {32'b0, instr_retired}, 64'd0);
`endif
    launch();
    check("nop_fetch_en", {63'b0, fetch_en}, 64'd1);
    check("nop_pc_fetch", pc, 64'h0);
    tick();
    check("nop_issue", {63'b0, issue}, 64'd1);
    check("nop_fetch_en_exec", {63'b0, fetch_en}, 64'd0);
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    check("nop_pc", pc, 64'h1);
    check("nop_issue_once", {63'b0, issue}, 64'd0);
    check("nop_stat", {61'b0, stat}, 64'd1);

    // 2: jXX not taken then taken
    set_fetch(4'h7, 4'h1, 64'h40, 64'h9);
    tick();
    check("jxx_ifun_q", {60'b0, ifun_q}, 64'd1);
    cnd = 1'b0; wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    check("jxx_nt_pc", pc, 64'h9);
    tick();
    cnd = 1'b1; wb_done = 1'b1;
    tick();
    wb_done = 1'b0; cnd = 1'b0;
    check("jxx_t_pc", pc, 64'h40);

    // 3: call then ret, icode_q held while fetch inputs change
    set_fetch(4'h8, 4'h0, 64'h100, 64'h49);
    tick();
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    check("call_pc", pc, 64'h100);
    set_fetch(4'h9, 4'h0, 64'h0, 64'h101);
    tick();
    set_fetch(4'h0, 4'h0, 64'h0, 64'h0);
    tick();
    check("ret_icode_q_held", {60'b0, icode_q}, 64'd9);
    check("ret_wait_pc", pc, 64'h100);
    check("ret_busy", {63'b0, busy}, 64'd1);
    check("ret_issue_low", {63'b0, issue}, 64'd0);
    valM = 64'h0A; wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    check("ret_pc", pc, 64'h0A);

    // 4: unconditional jmp to 0x20, halt there
    set_fetch(4'h7, 4'h0, 64'h20, 64'h13);
    tick();
    cnd = 1'b1; wb_done = 1'b1;
    tick();
    cnd = 1'b0; wb_done = 1'b0;
    check("jmp_pc", pc, 64'h20);
    set_fetch(4'h0, 4'h0, 64'h0, 64'h21);
    halt = 1'b1;
    tick();
    check("halt_stat", {61'b0, stat}, 64'd2);
    check("halt_pc", pc, 64'h20);
    check("halt_fetch_en", {63'b0, fetch_en}, 64'd0);
    check("halt_busy", {63'b0, busy}, 64'd0);
    start = 1'b1; halt = 1'b0; wb_done = 1'b1;
    tick();
    tick();
    start = 1'b0; wb_done = 1'b0;
    check("halt_sticky_stat", {61'b0, stat}, 64'd2);
    check("halt_sticky_pc", pc, 64'h20);
    check("halt_sticky_fetch_en", {63'b0, fetch_en}, 64'd0);
    check("halt_sticky_issue", {63'b0, issue}, 64'd0);
`ifdef PC_SEQ_PERF_EN
    check("retired_six", {32'b0, instr_retired}, 64'd6);
`endif

    // 5: fault priorities
    do_reset();
    launch();
    set_fetch(4'h1, 4'h0, 64'h0, 64'h1);
    imem_error = 1'b1; instr_valid = 1'b0; halt = 1'b1;
    tick();
    check("imem_stat", {61'b0, stat}, 64'd3);
    check("imem_pc", pc, 64'h0);
    do_reset();
    launch();
    set_fetch(4'h1, 4'h0, 64'h0, 64'h1);
    instr_valid = 1'b0; halt = 1'b1;
    tick();
    check("ins_stat", {61'b0, stat}, 64'd4);
    do_reset();
    launch();
    set_fetch(4'h1, 4'h0, 64'h0, 64'h5);
    tick();
    wb_done = 1'b1; dmem_error = 1'b1;
    tick();
    wb_done = 1'b0; dmem_error = 1'b0;
    check("dmem_stat", {61'b0, stat}, 64'd3);
    check("dmem_pc", pc, 64'h0);
    check("dmem_busy", {63'b0, busy}, 64'd0);
`ifdef PC_SEQ_PERF_EN
    check("dmem_retired", {32'b0, instr_retired}, 64'd0);
`endif

    // 6: reset during EXEC with wb_done pending
    do_reset();
    launch();
    set_fetch(4'h1, 4'h0, 64'h0, 64'h7);
    tick();
    check("abandon_issue", {63'b0, issue}, 64'd1);
    rst = 1'b1; wb_done = 1'b1;
    tick();
    rst = 1'b0;
    check("abandon_pc", pc, 64'h0);
    check("abandon_issue_low", {63'b0, issue}, 64'd0);
    check("abandon_busy", {63'b0, busy}, 64'd0);
    check("abandon_stat", {61'b0, stat}, 64'd1);
    tick();
    tick();
    wb_done = 1'b0;
    check("late_wb_pc", pc, 64'h0);
    check("late_wb_busy", {63'b0, busy}, 64'd0);
`ifdef PC_SEQ_PERF_EN
    check("abandon_retired", {32'b0, instr_retired}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
